// File: rtl/multdiv_sequencer_if.sv
// Control bundle between the multiply/divide sequencer and its datapath.
// Latency: none, wires only.
// Backpressure: none; requests arriving while the sequencer is busy are dropped.
interface multdiv_sequencer_if;
  // requests and datapath status flags
  logic       ctrl_MULT;
  logic       ctrl_DIV;
  logic       divisor_zero;
  logic       MSB;
  logic [1:0] booth_bits;
  // datapath step controls and status back to the requester
  logic       load;
  logic       add;
  logic       sub;
  logic       shift;
  logic       Q0;
  logic       sel_div;
  logic       busy;
  logic       data_resultRDY;
  logic       data_exception;
  logic [5:0] count;

  // requester / datapath side
  modport master (
    output ctrl_MULT, ctrl_DIV, divisor_zero, MSB, booth_bits,
    input  load, add, sub, shift, Q0, sel_div, busy,
           data_resultRDY, data_exception, count
  );

  // sequencer side
  modport slave (
    input  ctrl_MULT, ctrl_DIV, divisor_zero, MSB, booth_bits,
    output load, add, sub, shift, Q0, sel_div, busy,
           data_resultRDY, data_exception, count
  );
endinterface

// File: rtl/multdiv_sequencer.sv
// Booth multiply / non-restoring divide control sequencer (IDLE-LOAD-RUN-FIX-DONE).
// Latency: multiply result N+2 cycles, divide N+3, div-by-zero 2, conflicting request 1.
// Backpressure: none; requests while busy are ignored, a request in DONE starts back-to-back.
module multdiv_sequencer #(
  parameter int N = 32
) (
  input logic              clock,
  input logic              reset,
  multdiv_sequencer_if.slave sq
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [5:0] LAST_STEP = 6'(N - 1);

  state_t     state_q, state_d;
  logic [5:0] count_q, count_d;
  logic       sel_div_q, sel_div_d;
  logic       exc_q, exc_d;

  logic load_c, add_c, sub_c, shift_c, q0_c, busy_c, rdy_c, exc_out_c;

  // state, step counter, operation select and exception flag registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= 6'd0;
      sel_div_q <= 1'b0;
      exc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      sel_div_q <= sel_div_d;
      exc_q     <= exc_d;
    end
  end

  // next-state and per-state datapath controls
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    sel_div_d = sel_div_q;
    exc_d     = exc_q;
    load_c    = 1'b0;
    add_c     = 1'b0;
    sub_c     = 1'b0;
    shift_c   = 1'b0;
    q0_c      = 1'b0;
    busy_c    = 1'b0;
    rdy_c     = 1'b0;
    exc_out_c = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) begin
          rdy_c     = 1'b1;
          exc_out_c = exc_q;
          // flag lives only for the DONE cycle it is reported in
          exc_d     = 1'b0;
          state_d   = S_IDLE;
        end
        if (sq.ctrl_MULT ^ sq.ctrl_DIV) begin
          state_d   = S_LOAD;
          sel_div_d = sq.ctrl_DIV;
          count_d   = 6'd0;
        end else if (sq.ctrl_MULT && sq.ctrl_DIV) begin
          // ambiguous request: report straight away, never touch the datapath
          state_d = S_DONE;
          exc_d   = 1'b1;
        end
      end

      S_LOAD: begin
        load_c = 1'b1;
        busy_c = 1'b1;
        if (sel_div_q && sq.divisor_zero) begin
          state_d = S_DONE;
          exc_d   = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        busy_c  = 1'b1;
        shift_c = 1'b1;
        if (sel_div_q) begin
          // non-restoring step: sign of partial remainder picks add/sub and quotient bit
          add_c = sq.MSB;
          sub_c = ~sq.MSB;
          q0_c  = ~sq.MSB;
        end else begin
          // radix-2 Booth recoding of {Q[0], Q[-1]}
          add_c = (sq.booth_bits == 2'b01);
          sub_c = (sq.booth_bits == 2'b10);
        end
        if (count_q == LAST_STEP) begin
          state_d = sel_div_q ? S_FIX : S_DONE;
        end else begin
          count_d = count_q + 6'd1;
        end
      end

      S_FIX: begin
        // final remainder restore when it ended negative
        busy_c  = 1'b1;
        add_c   = sq.MSB;
        q0_c    = ~sq.MSB;
        state_d = S_DONE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign sq.load           = load_c;
  assign sq.add            = add_c;
  assign sq.sub            = sub_c;
  assign sq.shift          = shift_c;
  assign sq.Q0             = q0_c;
  assign sq.busy           = busy_c;
  assign sq.data_resultRDY = rdy_c;
  assign sq.data_exception = exc_out_c;
  assign sq.sel_div        = sel_div_q;
  assign sq.count          = count_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed + randomized bench for multdiv_sequencer with a cycle-indexed reference model.
// Latency: expectations derived from request-edge cycle numbers.
// Backpressure: random request noise injected while busy must be ignored.
module tb_multdiv_sequencer;

  localparam int N = 32;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  // model state carried between operations
  logic [5:0] model_count;
  logic       model_sel;

  multdiv_sequencer_if sif();

  multdiv_sequencer #(.N(N)) dut (
    .clock (clock),
    .reset (reset),
    .sq    (sif.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // observed bundle: {load,add,sub,shift,Q0,sel_div,busy,rdy,exc,count}
  task automatic check_vec(input string tag, input logic [14:0] exp_v);
    logic [14:0] obs;
    obs = {sif.load, sif.add, sif.sub, sif.shift, sif.Q0, sif.sel_div, sif.busy,
           sif.data_resultRDY, sif.data_exception, sif.count};
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // idle cycles: everything quiet, count and sel_div hold
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      sif.booth_bits   = 2'($urandom_range(0, 3));
      sif.MSB          = 1'($urandom_range(0, 1));
      sif.divisor_zero = 1'($urandom_range(0, 1));
      @(negedge clock);
      check_vec($sformatf("idle%0d", i), {5'b0, model_sel, 3'b0, model_count});
    end
  endtask

  // One operation: request seen at edge 0, cycle c is the period after edge c-1.
  // booth_fix/msb_from < 0 mean random; rep_k >= 0 re-pulses ctrl_MULT at that RUN step.
  task automatic do_op(input string name, input bit m, input bit d, input bit dz,
                       input int booth_fix, input int msb_from, input int rep_k,
                       input bit noise);
    bit both, mult_op, div_op, dz_exc;
    bit is_load, is_run, is_fix, is_done;
    int L, k;
    logic [1:0] bb;
    logic msb, a, s, q, sel;
    logic [5:0] cnt;
    both    = m && d;
    mult_op = m && !d;
    div_op  = d && !m;
    dz_exc  = div_op && dz;
    if (both)         L = 1;
    else if (dz_exc)  L = 2;
    else if (mult_op) L = N + 2;
    else              L = N + 3;
    cnt = model_count;
    sif.ctrl_MULT = m;
    sif.ctrl_DIV  = d;
    @(posedge clock);
    #1;
    sel = both ? model_sel : d;
    for (int c = 1; c <= L; c++) begin
      is_load = !both && c == 1;
      is_run  = !both && !dz_exc && c >= 2 && c <= N + 1;
      is_fix  = div_op && !dz_exc && c == N + 2;
      is_done = (c == L);
      k = c - 2;
      bb = (booth_fix >= 0) ? 2'(booth_fix) : 2'($urandom_range(0, 3));
      if (msb_from >= 0) msb = is_fix ? 1'b1 : (k >= msb_from);
      else               msb = 1'($urandom_range(0, 1));
      sif.booth_bits   = bb;
      sif.MSB          = msb;
      sif.divisor_zero = dz;
      sif.ctrl_MULT = (c < L) && ((is_run && k == rep_k) || (noise && $urandom_range(0, 1) == 1));
      sif.ctrl_DIV  = (c < L) && noise && ($urandom_range(0, 1) == 1);
      a = 1'b0; s = 1'b0; q = 1'b0;
      if (is_run && mult_op) begin
        a = (bb == 2'b01);
        s = (bb == 2'b10);
      end else if (is_run && div_op) begin
        a = msb; s = !msb; q = !msb;
      end else if (is_fix) begin
        a = msb; q = !msb;
      end
      if (both)        cnt = model_count;
      else if (is_run) cnt = 6'(k);
      else if (c == 1 || dz_exc) cnt = 6'd0;
      else             cnt = 6'(N - 1);
      @(negedge clock);
      check_vec($sformatf("%s c%0d", name, c),
                {is_load, a, s, is_run, q, sel, is_load || is_run || is_fix,
                 is_done, is_done && (both || dz_exc), cnt});
      if (c < L) begin
        @(posedge clock);
        #1;
      end
    end
    sif.ctrl_MULT = 1'b0;
    sif.ctrl_DIV  = 1'b0;
    model_count = cnt;
    model_sel   = sel;
  endtask

  initial begin
    int t;
    bit rm, rd, rz;
    checks = 0;
    errors = 0;
    model_count = 6'd0;
    model_sel   = 1'b0;
    reset = 1'b1;
    sif.ctrl_MULT    = 1'b0;
    sif.ctrl_DIV     = 1'b0;
    sif.divisor_zero = 1'b0;
    sif.MSB          = 1'b1;
    sif.booth_bits   = 2'b01;

    // reset state: all outputs low while reset is held
    #1;
    check_vec("reset_state", 15'd0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(2);

    // multiply with booth_bits held 10: sub+shift across the whole RUN
    do_op("mult_b10", 1'b1, 1'b0, 1'b0, 2, -1, -1, 1'b0);
    idle(1);
    // divide: MSB low for 5 steps then high, FIX restores
    do_op("div_msb5", 1'b0, 1'b1, 1'b0, -1, 5, -1, 1'b0);
    idle(1);
    // divide by zero
    do_op("div_zero", 1'b0, 1'b1, 1'b1, -1, -1, -1, 1'b0);
    idle(1);
    // simultaneous requests
    do_op("both_req", 1'b1, 1'b1, 1'b0, -1, -1, -1, 1'b0);
    idle(1);
    // multiply re-pulsed at count 10, then divide launched from DONE
    do_op("mult_rep", 1'b1, 1'b0, 1'b0, -1, -1, 10, 1'b0);
    do_op("div_b2b", 1'b0, 1'b1, 1'b0, -1, -1, -1, 1'b0);
    // back-to-back conflicting request from DONE, then a multiply from that DONE
    do_op("both_b2b", 1'b1, 1'b1, 1'b0, -1, -1, -1, 1'b0);
    do_op("mult_b2b", 1'b1, 1'b0, 1'b0, 0, -1, -1, 1'b0);
    idle(1);

    // reset asserted between edges in the middle of a multiply
    sif.booth_bits = 2'b00;
    sif.ctrl_MULT  = 1'b1;
    @(posedge clock);
    #1;
    sif.ctrl_MULT = 1'b0;
    repeat (16) @(posedge clock);
    #3;
    check_vec("rst_pre_count15", {3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 6'd15});
    reset = 1'b1;
    #1;
    check_vec("rst_async_zero", 15'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_vec($sformatf("rst_held%0d", i), 15'd0);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check_vec("rst_released", 15'd0);
    model_count = 6'd0;
    model_sel   = 1'b0;
    do_op("mult_after_rst", 1'b1, 1'b0, 1'b0, -1, -1, -1, 1'b0);

    // randomized operations with request noise while busy
    for (int i = 0; i < 8; i++) begin
      t  = $urandom_range(0, 3);
      rm = (t == 0) || (t == 3);
      rd = (t >= 1);
      rz = (t == 2) ? 1'b1 : ((t == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
      do_op($sformatf("rand%0d_t%0d", i, t), rm, rd, rz, -1, -1, -1, 1'b1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multdiv_sequencer.md
MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

Interface
REQ-001 SHALL have parameter N, default 32: operand width, which is also the RUN step count.
REQ-002 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high; one clock domain only.
REQ-004 SHALL have port ctrl_MULT, input, 1: multiply request, sampled at the rising edge.
REQ-005 SHALL have port ctrl_DIV, input, 1: divide request, sampled at the rising edge.
REQ-006 SHALL have port divisor_zero, input, 1: datapath flag that the divisor operand is zero, valid in LOAD.
REQ-007 SHALL have port MSB, input, 1: sign bit of the datapath partial remainder.
REQ-008 SHALL have port booth_bits, input, 2: multiplier register {Q[0], Q[-1]}.
REQ-009 SHALL have port load, output, 1: datapath loads operands and clears the accumulator.
REQ-010 SHALL have ports add, sub, shift, output, 1 each: datapath step controls.
REQ-011 SHALL have port Q0, output, 1: quotient bit to insert on this cycle.
REQ-012 SHALL have port sel_div, output, 1: registered; 1 = divide in progress.
REQ-013 SHALL have port busy, output, 1: operation in progress.
REQ-014 SHALL have ports data_resultRDY, data_exception, output, 1 each: completion pulse and error flag.
REQ-015 SHALL have port count, output, 6: current RUN step index.

Function
REQ-016 SHALL implement states IDLE, LOAD, RUN, FIX, DONE, encoded in registers.
REQ-017 In IDLE, ctrl_MULT xor ctrl_DIV SHALL move to LOAD, with sel_div <= ctrl_DIV and count <= 0.
REQ-018 In IDLE, ctrl_MULT and ctrl_DIV both high SHALL move to DONE with exception latched, and load SHALL NOT assert.
REQ-019 LOAD SHALL last one cycle, with load=1 and busy=1.
REQ-020 In LOAD, sel_div=1 with divisor_zero=1 SHALL move to DONE with exception latched; otherwise LOAD SHALL move to RUN.
REQ-021 RUN SHALL last exactly N cycles, with count stepping 0..N-1, shift=1 and busy=1 on every cycle.
REQ-022 Multiply RUN SHALL decode booth_bits: 01 -> add=1; 10 -> sub=1; 00/11 -> neither.
REQ-023 Divide RUN SHALL drive add=MSB, sub=~MSB, Q0=~MSB.
REQ-024 add and sub SHALL never be high together.
REQ-025 After count=N-1, RUN SHALL move to FIX if sel_div, else to DONE.
REQ-026 FIX SHALL last one cycle, with add=MSB (remainder restore), sub=0, shift=0, Q0=~MSB, busy=1.
REQ-027 DONE SHALL last one cycle, with data_resultRDY=1, data_exception equal to the latched flag, and busy=0.
REQ-028 After DONE the latched exception flag SHALL clear.
REQ-029 In DONE, a new request SHALL be accepted exactly as in IDLE (back-to-back operation); with no request, DONE SHALL move to IDLE.
REQ-030 While busy, ctrl_MULT and ctrl_DIV SHALL be ignored and SHALL NOT be queued.
REQ-031 Latency, counted from the request edge: multiply resultRDY in cycle N+2; divide in cycle N+3; exception cases in cycle 2 (divide by zero) or 1 (simultaneous requests).
REQ-032 Outside RUN and FIX, add, sub, shift and Q0 SHALL be 0; data_resultRDY SHALL be 0 outside DONE.
REQ-033 count SHALL hold its value outside RUN and SHALL NOT wrap past N-1.

Reset
REQ-034 reset high SHALL immediately force IDLE, count=0, sel_div=0 and the exception flag to 0, and drive every output to 0, independent of clock.
REQ-035 reset asserted mid-operation SHALL abort it with no data_resultRDY pulse; the first request after deassertion SHALL start cleanly.

Verification
REQ-036 The bench SHALL cover: ctrl_MULT pulse with booth_bits held 10 -> load in cycle 1, sub=1 and shift=1 in cycles 2..33, resultRDY=1 and exception=0 in cycle 34.
REQ-037 The bench SHALL cover: ctrl_DIV pulse, MSB=0 for the first 5 RUN cycles then MSB=1 -> sub=1/Q0=1 for those 5, then add=1/Q0=0; FIX in cycle 34, resultRDY in cycle 35.
REQ-038 The bench SHALL cover: ctrl_DIV with divisor_zero=1 -> load in cycle 1, resultRDY=1 and exception=1 in cycle 2, no shift ever.
REQ-039 The bench SHALL cover: ctrl_MULT and ctrl_DIV together -> resultRDY=1 and exception=1 in cycle 1, load never asserted.
REQ-040 The bench SHALL cover: ctrl_MULT re-pulsed at count=10, then ctrl_DIV pulsed in the DONE cycle -> the first pulse ignored, the divide's load in the cycle after DONE.
REQ-041 The bench SHALL cover: reset asserted at count=15 between clock edges -> all outputs 0 before the next edge, no resultRDY, and a following multiply completing in N+2 cycles.
